deserializer_sipo: RTL and testbench
====================================

// Module: deserializer_sipo
// PURPOSE
//   Serial-in/parallel-out receive stage, directly downstream of serializer_PISO.
//   Frames the serial bit stream, checks start and stop bits, and delivers each
//   DATA_WIDTH word through a one-entry valid/ready output buffer.
//   Reports framing errors and overruns as one-cycle pulses.
// PARAMETERS
//   DATA_WIDTH  8  payload bits per frame
// PORTS
//   clk         input   1           system clock, rising edge
//   rst         input   1           reset; asynchronous, active-low
//   srl_in      input   1           serial line; idles high
//   bit_en      input   1           bit strobe; srl_in is sampled only when bit_en=1
//   data_ready  input   1           consumer accepts data_out this cycle
//   data_out    output  DATA_WIDTH  received word, LSB = first data bit
//   data_valid  output  1           data_out holds an unread word
//   busy        output  1           FSM is not in IDLE
//   frame_err   output  1           1-cycle pulse: stop bit sampled as 0
//   overrun     output  1           1-cycle pulse: good frame dropped, buffer full
// BEHAVIOUR
//   Frame format: start(0), DATA_WIDTH bits LSB first, stop(1). One bit per bit_en.
//   Cycles with bit_en=0 change nothing except the output handshake.
//   Reset (rst=0, async): FSM=IDLE, shift reg=0, bit_cnt=0, data_out=0,
//     data_valid=0, busy=0, frame_err=0, overrun=0. A partial frame is discarded.
//   FSM states and transitions:
//     IDLE    - bit_en & srl_in=0 -> DATA, bit_cnt=0. bit_en & srl_in=1 -> stay.
//     DATA    - on bit_en: shreg <= {srl_in, shreg[DATA_WIDTH-1:1]}, bit_cnt++.
//               When bit_cnt==DATA_WIDTH-1 on bit_en -> STOP.
//     STOP    - on bit_en & srl_in=1: good frame -> IDLE (see output buffer).
//               on bit_en & srl_in=0: frame_err pulse, word discarded -> RECOVER.
//     RECOVER - wait for bit_en & srl_in=1 -> IDLE. No start bit is accepted
//               until the line is sampled high once.
//   bit_cnt width is $clog2(DATA_WIDTH), minimum 1. It wraps only by leaving DATA.
//   Output buffer (one entry):
//     - A good frame loads data_out and sets data_valid on the next clk edge, so
//       data_valid rises 1 cycle after the stop-bit bit_en cycle.
//     - Load is allowed if data_valid=0, or if data_valid & data_ready in the same
//       cycle (simultaneous read and load: the new word replaces the old one and
//       data_valid stays 1).
//     - Otherwise overrun pulses for 1 cycle, the new word is dropped, and the
//       old data_out and data_valid are kept.
//     - data_valid & data_ready with no load -> data_valid=0 next cycle.
//     - data_out is stable while data_valid=1. data_ready is ignored while
//       data_valid=0.
//   busy = (state != IDLE), registered together with the state.
//   frame_err and overrun are registered and high for exactly 1 clk.
//   Throughput: back-to-back frames with no idle bits are supported. The stop
//     bit is followed directly by the next start bit.
// TESTING
//   1. rst=0 mid-frame (after 3 data bits), then release -> all outputs 0, FSM
//      IDLE; the next full frame 0xA5 is received correctly.
//   2. Frame 0xA5 (bits 1,0,1,0,0,1,0,1), bit_en every 4 clk, data_ready=1 ->
//      data_out=0xA5, data_valid high 1 cycle after the stop-bit strobe.
//   3. Stop bit=0 on frame 0x3C -> frame_err 1-cycle pulse, data_valid stays 0;
//      a start bit before the line returns high is ignored; after a high sample,
//      0x3C is received.
//   4. data_ready=0, frames 0x11 then 0x22 -> data_out stays 0x11, overrun
//      pulses once at the 0x22 stop bit; raise data_ready -> data_valid falls.
//   5. data_ready=1 in the same cycle as the 0x22 load -> data_out=0x22,
//      data_valid stays high, no overrun.
//   6. Back-to-back frames 0x00, 0xFF, 0x80 with bit_en=1 every cycle -> three
//      words in order, no frame_err, no overrun.

Source files
------------

// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: frames start/data/stop bits and
// hands each word to a one-entry valid/ready output buffer.
module deserializer_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  bit_en,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [DATA_WIDTH:0]   sh_tmp;
  logic [CW-1:0]         bit_cnt, cnt_nx;
  logic                  good, ferr_nx;
  logic                  load, ovr_nx, dv_nx;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    good     = 1'b0;
    ferr_nx  = 1'b0;
    sh_tmp   = {srl_in, shreg};
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!srl_in) begin
            state_nx = DATA;
            cnt_nx   = '0;
          end
        end
        DATA: begin
          shreg_nx = sh_tmp[DATA_WIDTH:1];
          if (bit_cnt == LAST) begin
            state_nx = STOP;
            cnt_nx   = '0;
          end else begin
            cnt_nx = bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (srl_in) begin
            good     = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = RECOVER;
          end
        end
        RECOVER: begin
          if (srl_in) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // a full buffer may still load when it is read in the same cycle
  always_comb begin
    load   = good & (~data_valid | data_ready);
    ovr_nx = good & ~load;
    dv_nx  = data_valid;
    if (load)
      dv_nx = 1'b1;
    else if (data_valid && data_ready)
      dv_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != IDLE);
      shreg      <= shreg_nx;
      bit_cnt    <= cnt_nx;
      data_valid <= dv_nx;
      frame_err  <= ferr_nx;
      overrun    <= ovr_nx;
      if (load) data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_deserializer_sipo.sv
// Bench for deserializer_sipo: frame table, directed corner
// sequences and random traffic against a queue-based model.
module tb_deserializer_sipo;

  localparam int DW = 8;

  logic          tb_clk;
  logic          rst;
  logic          srl_in;
  logic          bit_en;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  deserializer_sipo #(.DATA_WIDTH(DW)) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .srl_in    (srl_in),
    .bit_en    (bit_en),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic rdy    = 1'b0;
  logic [DW-1:0] rx_q[$];

  // reference: 0 idle, 1 collecting data, 2 expect stop, 3 wait high
  int            m_mode;
  bit            m_bits[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ferr;
  logic          m_ovr;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_bits.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic en,
                            input logic rd);
    logic          good;
    logic [DW-1:0] word;
    good   = 1'b0;
    word   = '0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (en) begin
      if (m_mode == 0) begin
        if (!s) begin
          m_mode = 1;
          m_bits.delete();
        end
      end else if (m_mode == 1) begin
        m_bits.push_back(s);
        if (m_bits.size() == DW) m_mode = 2;
      end else if (m_mode == 2) begin
        if (s) begin
          good = 1'b1;
          for (int i = 0; i < DW; i++) word[i] = m_bits[i];
          m_mode = 0;
        end else begin
          m_ferr = 1'b1;
          m_mode = 3;
        end
      end else if (s) begin
        m_mode = 0;
      end
    end
    if (good) begin
      if (!m_valid || rd) begin
        m_valid = 1'b1;
        m_data  = word;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic s, input logic en);
    srl_in     = s;
    bit_en     = en;
    data_ready = rdy;
    if (data_valid && data_ready) rx_q.push_back(data_out);
    @(posedge tb_clk);
    model_step(s, en, rdy);
    #1;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    check("model",
          {20'd0, data_out, data_valid, busy, frame_err, overrun},
          {20'd0, m_data, m_valid, (m_mode != 0), m_ferr, m_ovr});
  endtask

  task automatic send_bit(input logic b, input int gap);
    cycle(b, 1'b1);
    repeat (gap - 1) cycle(b, 1'b0);
  endtask

  task automatic send_data(input logic [DW-1:0] d, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < DW; i++) send_bit(d[i], gap);
  endtask

  task automatic check_rx(input string name,
                          input logic [DW-1:0] exp[$]);
    check({name, "_cnt"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({name, "_word"}, rx_q[i], exp[i]);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          ready;
    int            gap;
    logic [DW-1:0] exp_out;
    logic          exp_valid;
    logic          exp_ferr;
    logic          exp_ovr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f0, o0;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 4, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 2, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 1'b0, 1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h0F, 1'b1, 1'b1, 1, 8'h0F, 1'b1, 1'b0, 1'b0};

    rst        = 1'b0;
    srl_in     = 1'b1;
    bit_en     = 1'b0;
    data_ready = 1'b0;
    model_reset();
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_outputs",
          {data_valid, busy, frame_err, overrun}, 0);
    @(posedge tb_clk);
    #1 rst = 1'b1;

    // reset in the middle of a frame
    rdy = 1'b1;
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    check("midframe_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_outputs",
          {data_out, data_valid, busy, frame_err, overrun}, 0);
    @(posedge tb_clk);
    #1 rst = 1'b1;
    model_reset();
    rx_q.delete();
    send_data(8'hA5, 1);
    send_bit(1'b1, 1);
    repeat (2) cycle(1'b1, 1'b0);
    check_rx("after_rst_rx", '{8'hA5});

    // stop strobe timing with bit_en every 4 clk
    rdy = 1'b1;
    send_data(8'hA5, 4);
    check("pre_stop_valid", data_valid, 0);
    cycle(1'b1, 1'b1);
    check("stop_valid_rise", data_valid, 1);
    check("stop_data", data_out, 8'hA5);
    repeat (3) cycle(1'b1, 1'b0);
    check("valid_drop", data_valid, 0);

    // table: each row is followed by one high sample
    foreach (vecs[k]) begin
      rdy = vecs[k].ready;
      send_data(vecs[k].data, vecs[k].gap);
      cycle(vecs[k].stop, 1'b1);
      check($sformatf("vec%0d_out", k),
            data_out, vecs[k].exp_out);
      check($sformatf("vec%0d_flags", k),
            {data_valid, frame_err, overrun},
            {vecs[k].exp_valid, vecs[k].exp_ferr,
             vecs[k].exp_ovr});
      repeat (vecs[k].gap - 1) cycle(1'b1, 1'b0);
      send_bit(1'b1, 1);
    end
    rdy = 1'b1;
    repeat (2) cycle(1'b1, 1'b0);

    // framing error, then a start bit while recovering
    rx_q.delete();
    f0 = ferr_cnt;
    send_data(8'h3C, 1);
    send_bit(1'b0, 1);
    send_bit(1'b0, 1);
    send_bit(1'b0, 1);
    check("recover_busy", busy, 1);
    check("ferr_pulse_cnt", ferr_cnt - f0, 1);
    check("ferr_no_valid", data_valid, 0);
    send_bit(1'b1, 1);
    check("recover_idle", busy, 0);
    send_data(8'h3C, 1);
    send_bit(1'b1, 1);
    repeat (2) cycle(1'b1, 1'b0);
    check_rx("ferr_rx", '{8'h3C});

    // overrun with the consumer stalled
    rx_q.delete();
    rdy = 1'b0;
    o0  = ovr_cnt;
    send_data(8'h11, 1);
    send_bit(1'b1, 1);
    send_data(8'h22, 1);
    send_bit(1'b1, 1);
    check("ovr_pulse", overrun, 1);
    check("ovr_keep_data", data_out, 8'h11);
    cycle(1'b1, 1'b0);
    check("ovr_once", ovr_cnt - o0, 1);
    check("ovr_keep_valid", data_valid, 1);
    rdy = 1'b1;
    cycle(1'b1, 1'b0);
    check("ovr_read_drop", data_valid, 0);
    check_rx("ovr_rx", '{8'h11});

    // read and load in the same cycle
    rx_q.delete();
    rdy = 1'b0;
    o0  = ovr_cnt;
    send_data(8'h11, 1);
    send_bit(1'b1, 1);
    send_data(8'h22, 1);
    rdy = 1'b1;
    cycle(1'b1, 1'b1);
    check("simul_data", data_out, 8'h22);
    check("simul_valid", data_valid, 1);
    check("simul_no_ovr", ovr_cnt - o0, 0);
    cycle(1'b1, 1'b0);
    check_rx("simul_rx", '{8'h11, 8'h22});

    // back-to-back frames, bit_en every cycle
    rx_q.delete();
    rdy = 1'b1;
    f0  = ferr_cnt;
    o0  = ovr_cnt;
    send_data(8'h00, 1);
    send_bit(1'b1, 1);
    send_data(8'hFF, 1);
    send_bit(1'b1, 1);
    send_data(8'h80, 1);
    send_bit(1'b1, 1);
    repeat (3) cycle(1'b1, 1'b0);
    check_rx("b2b_rx", '{8'h00, 8'hFF, 8'h80});
    check("b2b_no_err",
          (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
            $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
